// File: rtl/uart_rx_op.sv
// UART receiver: oversampled 8-bit frame recovery with optional parity.
// Emits each byte with a one-cycle valid strobe and per-frame error flags.
module uart_rx_op #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit VERIFY_ON    = 1'b0,
  parameter bit VERIFY_EVEN  = 1'b0
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       uart_rx_i,
  output logic [7:0] dataout_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       uart_busy_o
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t state_q, state_d;

  logic          rx_meta_q, rx_s_q, rx_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [7:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
  logic          exp_par;

  assign exp_par = VERIFY_EVEN ? (^shreg_q) : (~^shreg_q);

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
      rx_q      <= rx_s_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (rx_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == MID) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d              = '0;
          shreg_d[bit_cnt_q] = rx_s_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = VERIFY_ON ? PARITY : STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          dout_d  = shreg_q;
          valid_d = 1'b1;
          ferr_d  = ~rx_s_q;
          perr_d  = VERIFY_ON & (par_q != exp_par);
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign dataout_o    = dout_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign uart_busy_o  = busy_q;

endmodule
